// File: rtl/mux_src_arbiter.sv
// Round-robin source arbiter feeding a 2:1 mux; word reaches the mux two edges after its accept.
// One-entry holding register per channel; out_valid/sel/word hold steady while out_ready is low.
module mux_src_arbiter #(
  parameter int width_size = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [width_size:0] in0_data,
  input  logic                in0_valid,
  output logic                in0_ready,
  input  logic [width_size:0] in1_data,
  input  logic                in1_valid,
  output logic                in1_ready,
  output logic [width_size:0] d0,
  output logic [width_size:0] d1,
  output logic                sel,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SERVE = 1'b1;

  logic [0:0]          state;
  logic                full0;
  logic                full1;
  logic                last;
  logic [width_size:0] hold0;
  logic [width_size:0] hold1;
  logic                full_other;

  assign in0_ready  = ~full0;
  assign in1_ready  = ~full1;
  assign d0         = hold0;
  assign d1         = hold1;
  assign out_valid  = (state == SERVE);
  assign full_other = sel ? full0 : full1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      full0 <= 1'b0;
      full1 <= 1'b0;
      hold0 <= '0;
      hold1 <= '0;
      sel   <= 1'b0;
      last  <= 1'b1;
    end else begin
      // A full holding register is never overwritten, so an accept and a pop
      // can never target the same channel in one cycle.
      if (in0_valid && !full0) begin
        hold0 <= in0_data;
        full0 <= 1'b1;
      end
      if (in1_valid && !full1) begin
        hold1 <= in1_data;
        full1 <= 1'b1;
      end

      if (state == IDLE) begin
        if (full0 && full1) begin
          sel   <= ~last;
          state <= SERVE;
        end else if (full0) begin
          sel   <= 1'b0;
          state <= SERVE;
        end else if (full1) begin
          sel   <= 1'b1;
          state <= SERVE;
        end
      end else if (out_ready) begin
        if (sel) full1 <= 1'b0;
        else     full0 <= 1'b0;
        last <= sel;
        // Decision uses registered full: a same-cycle accept waits one cycle.
        if (full_other) sel   <= ~sel;
        else            state <= IDLE;
      end
    end
  end

endmodule
